// File: rtl/led_pwr_seq.sv
// led_pwr_seq: debounced power sequencer driving active-low LEDs through OFF, lamp-test and RUN states
module led_pwr_seq #(
    parameter int                 NUM_LED      = 16,
    parameter int                 DEB_CYCLES   = 4,
    parameter int                 LAMP_CYCLES  = 8,
    parameter int                 BLINK_HALF   = 16,
    parameter logic [NUM_LED-1:0] STBY_MASK    = NUM_LED'(1),
    parameter logic               PWR_ON_LEVEL = 1'b1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               pwr_en,
    input  logic [NUM_LED-1:0] led_in_n,
    input  logic               lamp_test_en,
    input  logic               stby_blink_en,
    input  logic               force_test,
    output logic [NUM_LED-1:0] led_n,
    output logic [1:0]         state_o,
    output logic               pwr_on_o
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int LW = $clog2(LAMP_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [LW-1:0] LAMP_LAST  = LW'(LAMP_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {S_OFF = 2'b00, S_LAMP = 2'b01, S_RUN = 2'b10} state_t;

    state_t             state;
    logic [1:0]         sync;
    logic [DW-1:0]      deb_cnt;
    logic [LW-1:0]      lamp_cnt, lamp_next;
    logic [BW-1:0]      blink_cnt, blink_next;
    logic               blink_phase, phase_next, pwr_sync, deb_done, go_off;
    logic [NUM_LED-1:0] off_led;

    assign state_o = state;

    // Blink counter and lamp counter sit at their entry values outside the states that use them
    always_comb begin
        pwr_sync   = sync[1] == PWR_ON_LEVEL;
        deb_done   = pwr_sync != pwr_on_o && deb_cnt == DEB_LAST;
        go_off     = state != S_OFF && (!pwr_on_o || (state != S_LAMP && state != S_RUN));
        phase_next = state != S_OFF ? 1'b1 : blink_cnt == BLINK_LAST ? ~blink_phase : blink_phase;
        blink_next = (state != S_OFF || blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
        lamp_next  = (state == S_LAMP && lamp_cnt != '0) ? lamp_cnt - 1'b1 : LAMP_LAST;
        off_led    = ~(STBY_MASK & {NUM_LED{stby_blink_en & phase_next}});
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync        <= {2{~PWR_ON_LEVEL}};
            deb_cnt     <= '0;
            pwr_on_o    <= 1'b0;
            lamp_cnt    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            state       <= S_OFF;
            led_n       <= '1;
        end else begin
            sync        <= {sync[0], pwr_en};
            deb_cnt     <= (pwr_sync == pwr_on_o || deb_done) ? '0 : deb_cnt + 1'b1;
            if (deb_done) pwr_on_o <= pwr_sync;
            blink_cnt   <= blink_next;
            blink_phase <= phase_next;
            lamp_cnt    <= lamp_next;
            if (go_off) begin
                state <= S_OFF;
                led_n <= off_led;
            end else begin
                case (state)
                    S_OFF: begin
                        if (pwr_on_o) begin
                            state <= lamp_test_en ? S_LAMP : S_RUN;
                            led_n <= lamp_test_en ? '0 : led_in_n;
                        end else begin
                            led_n <= off_led;
                        end
                    end
                    S_LAMP: begin
                        if (lamp_cnt == '0) begin
                            state <= S_RUN;
                            led_n <= led_in_n;
                        end else begin
                            led_n <= '0;
                        end
                    end
                    S_RUN: begin
                        if (force_test) begin
                            state <= S_LAMP;
                            led_n <= '0;
                        end else begin
                            led_n <= led_in_n;
                        end
                    end
                    default: begin
                        state <= S_OFF;
                        led_n <= off_led;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_pwr_seq.sv
// tb_led_pwr_seq: vector table, directed corner sequences and a randomized run against a timestamp-based model
module tb_led_pwr_seq;
    localparam int DEB = 4;
    localparam int LAMP = 8;
    localparam int BH = 16;

    logic        CLK = 1'b0, RST_N = 1'b0, pwr_en = 1'b0, lamp_test_en = 1'b1;
    logic        stby_blink_en = 1'b1, force_test = 1'b0;
    logic [15:0] led_in_n = 16'hFFFF, led_n;
    logic [1:0]  state_o;
    logic        pwr_on_o;
    int          checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    led_pwr_seq dut (
        .CLK(CLK), .RST_N(RST_N), .pwr_en(pwr_en), .led_in_n(led_in_n),
        .lamp_test_en(lamp_test_en), .stby_blink_en(stby_blink_en), .force_test(force_test),
        .led_n(led_n), .state_o(state_o), .pwr_on_o(pwr_on_o)
    );

    typedef struct packed {
        logic        pe;
        logic [15:0] li;
        logic [15:0] el;
        logic [1:0]  es;
        logic        eo;
    } vec_t;
    vec_t tbl[$];

    // Reference model: pwr_en history plus timestamps of OFF entry and lamp end
    bit          hist[$];
    int          t, t_off, lamp_end;
    logic [1:0]  m_st;
    bit          m_on;
    logic [15:0] m_led;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (state_o !== s && n < budget);
        chk("wait_state", {14'd0, state_o}, {14'd0, s});
    endtask

    function automatic bit sync_at(input int e);
        return e >= 3 ? hist[e-3] : 1'b0;
    endfunction

    task automatic model_reset();
        hist.delete();
        t = 0; t_off = 0; lamp_end = 0; m_st = 2'd0; m_on = 1'b0;
    endtask

    task automatic model_edge(input bit pe, input bit ft, input bit le, input bit se, input logic [15:0] li);
        bit flip;
        t++;
        hist.push_back(pe);
        flip = t >= DEB;
        for (int k = t - DEB + 1; k <= t && flip; k++) if (sync_at(k) == m_on) flip = 1'b0;
        if (m_st != 2'd0 && !m_on) begin
            m_st = 2'd0;
            t_off = t;
        end else if (m_st == 2'd0) begin
            if (m_on) begin
                m_st = le ? 2'd1 : 2'd2;
                lamp_end = t + LAMP;
            end
        end else if (m_st == 2'd1) begin
            if (t == lamp_end) m_st = 2'd2;
        end else if (ft) begin
            m_st = 2'd1;
            lamp_end = t + LAMP;
        end
        if (flip) m_on = !m_on;
        m_led = m_st == 2'd1 ? 16'h0000 : m_st == 2'd2 ? li :
                (se && ((t - t_off) / BH) % 2 == 0) ? 16'hFFFE : 16'hFFFF;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        chk("reset led_n", led_n, 16'hFFFF);
        chk("reset state", {14'd0, state_o}, 16'd0);
        tick();
        RST_N = 1'b1;
        model_reset();
    endtask

    initial begin
        int n, hold;
        bit pe_cur;
        for (int i = 0; i < 6; i++) tbl.push_back('{1'b1, 16'hFFF0, 16'hFFFF, 2'd0, i == 5});
        for (int i = 0; i < 8; i++) tbl.push_back('{1'b1, 16'hFFF0, 16'h0000, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 16'hFFF0, 16'hFFF0, 2'd2, 1'b1});
        tbl.push_back('{1'b1, 16'hA5A5, 16'hA5A5, 2'd2, 1'b1});
        tbl.push_back('{1'b1, 16'h0F0F, 16'h0F0F, 2'd2, 1'b1});
        for (int i = 0; i < 9; i++) tbl.push_back('{i >= 3, 16'h1234, 16'h1234, 2'd2, 1'b1});
        for (int i = 0; i < 7; i++)
            tbl.push_back('{i == 6, 16'hFFF0, i == 6 ? 16'hFFFF : 16'hFFF0, i == 6 ? 2'd0 : 2'd2, i < 5});

        // Reset with blink requested: outputs must still be blank
        tick();
        tick();
        chk("rst led_n", led_n, 16'hFFFF);
        chk("rst state", {14'd0, state_o}, 16'd0);
        chk("rst pwr_on", {15'd0, pwr_on_o}, 16'd0);
        stby_blink_en = 1'b0;
        RST_N = 1'b1;

        foreach (tbl[i]) begin
            pwr_en = tbl[i].pe;
            led_in_n = tbl[i].li;
            tick();
            chk($sformatf("vec%0d led_n", i), led_n, tbl[i].el);
            chk($sformatf("vec%0d state", i), {14'd0, state_o}, {14'd0, tbl[i].es});
            chk($sformatf("vec%0d pwr_on", i), {15'd0, pwr_on_o}, {15'd0, tbl[i].eo});
        end

        // Standby blink from the OFF entry edge
        lamp_test_en = 1'b0;
        pwr_en = 1'b1;
        wait_state(2'd2, 30);
        stby_blink_en = 1'b1;
        pwr_en = 1'b0;
        wait_state(2'd0, 30);
        for (int k = 0; k < 48; k++) begin
            if (k > 0) tick();
            chk($sformatf("blink k%0d", k), led_n, ((k / BH) % 2) == 1 ? 16'hFFFF : 16'hFFFE);
        end

        // Forced lamp test, second pulse during LAMP must not extend it
        stby_blink_en = 1'b0;
        lamp_test_en = 1'b1;
        led_in_n = 16'hFFF0;
        pwr_en = 1'b1;
        wait_state(2'd2, 40);
        for (int k = 0; k <= 8; k++) begin
            force_test = (k == 0 || k == 3);
            tick();
            force_test = 1'b0;
            chk($sformatf("force led k%0d", k), led_n, k < 8 ? 16'h0000 : 16'hFFF0);
            chk($sformatf("force state k%0d", k), {14'd0, state_o}, k < 8 ? 16'd1 : 16'd2);
        end

        // force_test on the OFF entry edge loses to power-off
        pwr_en = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (pwr_on_o !== 1'b0 && n < 20);
        chk("pwr_on fall", {15'd0, pwr_on_o}, 16'd0);
        force_test = 1'b1;
        tick();
        force_test = 1'b0;
        chk("force at off state", {14'd0, state_o}, 16'd0);
        chk("force at off led", led_n, 16'hFFFF);
        tick();
        chk("force at off hold", {14'd0, state_o}, 16'd0);

        // Async reset mid-LAMP, then full debounce before LAMP again
        pwr_en = 1'b1;
        wait_state(2'd1, 20);
        tick();
        chk("lamp before rst", {14'd0, state_o}, 16'd1);
        #3 RST_N = 1'b0;
        #1;
        chk("async rst led", led_n, 16'hFFFF);
        chk("async rst state", {14'd0, state_o}, 16'd0);
        chk("async rst pwr_on", {15'd0, pwr_on_o}, 16'd0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("rst relaunch state e%0d", k), {14'd0, state_o}, k < 7 ? 16'd0 : 16'd1);
            chk($sformatf("rst relaunch led e%0d", k), led_n, k < 7 ? 16'hFFFF : 16'h0000);
        end

        // Randomized run against the model
        do_reset();
        hold = 0;
        pe_cur = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) do_reset();
            if (hold == 0) begin
                pe_cur = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end
            hold--;
            pwr_en = pe_cur;
            force_test = $urandom_range(0, 7) == 0;
            lamp_test_en = $urandom_range(0, 3) != 0;
            stby_blink_en = $urandom_range(0, 1) == 1;
            led_in_n = 16'($urandom);
            tick();
            model_edge(pwr_en, force_test, lamp_test_en, stby_blink_en, led_in_n);
            chk($sformatf("rnd%0d led_n", i), led_n, m_led);
            chk($sformatf("rnd%0d state", i), {14'd0, state_o}, {14'd0, m_st});
            chk($sformatf("rnd%0d pwr_on", i), {15'd0, pwr_on_o}, {15'd0, m_on});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
